// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the program-counter block.
// Define PC_JR_EN to add the register-indirect (jr) next-PC source.
package pc_pkg;

    localparam int PC_WIDTH = 32;
    localparam int PC_INC   = 4;
    localparam int JIDX_MSB = 25;
    localparam int IMM_MSB  = 15;

    localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEQ,
        BRANCH,
`ifdef PC_JR_EN
        JR,
`endif
        JUMP
    } pc_src_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC computation: sequential, branch, jump (and jr with PC_JR_EN).
// Macro PC_JR_EN adds i_jump_reg / i_rs_data at highest priority.
module pc_target_calc
    import pc_pkg::*;
(
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_instr,
    input  logic                i_zero,
    input  logic                i_branch,
    input  logic                i_jump,
`ifdef PC_JR_EN
    input  logic                i_jump_reg,
    input  logic [PC_WIDTH-1:0] i_rs_data,
`endif
    output logic [PC_WIDTH-1:0] o_next_pc
);

    logic [PC_WIDTH-1:0] w_pc4;
    logic [PC_WIDTH-1:0] w_br_off;
    logic [PC_WIDTH-1:0] w_br_target;
    logic [PC_WIDTH-1:0] w_jmp_target;
    pc_src_e             w_src;
    logic                w_unused_opcode;

    // Opcode bits are decoded by the control unit, not here.
    assign w_unused_opcode = ^i_instr[PC_WIDTH-1:JIDX_MSB+1];

    assign w_pc4        = i_pc + PC_WIDTH'(PC_INC);
    assign w_br_off     = {{(PC_WIDTH-IMM_MSB-3){i_instr[IMM_MSB]}}, i_instr[IMM_MSB:0], 2'b00};
    assign w_br_target  = w_pc4 + w_br_off;
    assign w_jmp_target = {w_pc4[PC_WIDTH-1:JIDX_MSB+3], i_instr[JIDX_MSB:0], 2'b00};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_src     = SEQ;
        o_next_pc = w_pc4;
`ifdef PC_JR_EN
        if (i_jump_reg)
            w_src = JR;
        else
`endif
        if (i_jump)
            w_src = JUMP;
        else if (i_branch && i_zero)
            w_src = BRANCH;

        case (w_src)
            BRANCH:  o_next_pc = w_br_target;
            JUMP:    o_next_pc = w_jmp_target;
`ifdef PC_JR_EN
            JR:      o_next_pc = i_rs_data;
`endif
            default: o_next_pc = w_pc4;
        endcase
    end

endmodule

// File: rtl/pc.sv
// Program-counter register for the single-cycle MIPS datapath: reset, enable and hold.
// Macro PC_JR_EN adds JumpReg / rs_data for register-indirect jumps.
module pc
    import pc_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [PC_WIDTH-1:0] instr,
    input  logic                Zero,
    input  logic                Branch,
    input  logic                Jump,
`ifdef PC_JR_EN
    input  logic                JumpReg,
    input  logic [PC_WIDTH-1:0] rs_data,
`endif
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] nextPC
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_next_pc;

    pc_target_calc u_target_calc (
        .i_pc       (r_pc),
        .i_instr    (instr),
        .i_zero     (Zero),
        .i_branch   (Branch),
        .i_jump     (Jump),
`ifdef PC_JR_EN
        .i_jump_reg (JumpReg),
        .i_rs_data  (rs_data),
`endif
        .o_next_pc  (w_next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_VECTOR;
        else if (en)
            r_pc <= w_next_pc;
    end

    assign PC     = r_pc;
    assign nextPC = w_next_pc;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed corner cases plus randomized run against an arithmetic model.
// Define PC_JR_EN to also exercise the register-indirect jump path.
module tb_pc;

    logic        clk = 1'b0;
    logic        reset, en, Zero, Branch, Jump;
    logic [31:0] instr, PC, nextPC;
    logic        JumpReg;
    logic [31:0] rs_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .instr   (instr),
        .Zero    (Zero),
        .Branch  (Branch),
        .Jump    (Jump),
`ifdef PC_JR_EN
        .JumpReg (JumpReg),
        .rs_data (rs_data),
`endif
        .PC      (PC),
        .nextPC  (nextPC)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: next address from the architectural rules, plain arithmetic.
    function automatic logic [31:0] model(input logic [31:0] pc_v, input logic [31:0] ins,
                                          input logic b, input logic z, input logic j,
                                          input logic jr, input logic [31:0] rs);
        logic [31:0] pc4;
        int          off;
        pc4 = pc_v + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        if (jr) return rs;
        if (j)  return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b && z) return pc4 + 32'(off);
        return pc4;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic b, input logic z, input logic j);
        instr  = ins;
        Branch = b;
        Zero   = z;
        Jump   = j;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Steer the PC to an aligned target using jumps and maximal branches.
    task automatic goto_pc(input logic [31:0] tgt);
        int                 n;
        logic [31:0]        p4;
        logic signed [31:0] d;
        logic signed [31:0] dir;
        n = 0;
        while (PC !== tgt && n < 20000) begin
            p4  = PC + 32'd4;
            d   = tgt - p4;
            dir = tgt - PC;
            en  = 1'b1;
            if (p4[31:28] == tgt[31:28])
                drive({6'h02, tgt[27:2]}, 1'b0, 1'b0, 1'b1);
            else if (d >= -32'sh20000 && d <= 32'sh1FFFC)
                drive({16'h1000, d[17:2]}, 1'b1, 1'b1, 1'b0);
            else
                drive({16'h1000, (dir < 0) ? 16'h8000 : 16'h7FFF}, 1'b1, 1'b1, 1'b0);
            tick();
            n++;
        end
        en = 1'b0;
        check("goto_pc", PC, tgt);
    endtask

    logic [31:0] exp_pc;
    logic [31:0] exp_next;

    initial begin
        reset = 1'b1; en = 1'b0; JumpReg = 1'b0; rs_data = 32'h0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tick(); tick();
        reset = 1'b0;
        check("reset_pc", PC, 32'h0000_0000);

        drive(32'h5555_5555, 1'b1, 1'b0, 1'b0);
        check("branch_not_taken", nextPC, 32'h0000_0004);
        drive(32'h5555_5555, 1'b1, 1'b1, 1'b0);
        check("branch_taken", nextPC, 32'h0001_5558);
        drive(32'h5555_5555, 1'b1, 1'b1, 1'b1);
        check("jump_over_branch", nextPC, 32'h0555_5554);
        drive(32'h5555_5555, 1'b0, 1'b0, 1'b1);
        check("jump_only", nextPC, 32'h0555_5554);

        goto_pc(32'h0000_0100);
        drive(32'h1000_FFFF, 1'b1, 1'b1, 1'b0);
        check("self_loop", nextPC, 32'h0000_0100);
        goto_pc(32'h0000_00FC);
        drive(32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
        check("neg_imm_not_taken", nextPC, 32'h0000_0100);

        goto_pc(32'hFFFF_FFFC);
        drive(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        check("wrap", nextPC, 32'h0000_0000);
        goto_pc(32'hA000_0000);
        drive(32'h0800_0000, 1'b0, 1'b0, 1'b1);
        check("jump_region", nextPC, 32'hA000_0000);

        // Clocked sequence: reset, three increments, hold, reset over enable.
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; en = 1'b0;
        tick(); tick();
        check("seq_reset", PC, 32'h0000_0000);
        reset = 1'b0; en = 1'b1;
        tick(); check("seq_inc1", PC, 32'd4);
        tick(); check("seq_inc2", PC, 32'd8);
        tick(); check("seq_inc3", PC, 32'd12);
        en = 1'b0;
        tick(); tick(); check("seq_hold", PC, 32'd12);
        reset = 1'b1; en = 1'b1;
        tick(); check("reset_over_en", PC, 32'h0000_0000);
        reset = 1'b0;

`ifdef PC_JR_EN
        JumpReg = 1'b1; rs_data = 32'h0040_0020;
        drive(32'h5555_5555, 1'b1, 1'b1, 1'b1);
        check("jr_priority", nextPC, 32'h0040_0020);
        JumpReg = 1'b0;
`endif

        exp_pc = 32'h0;
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 31) == 0);
`ifdef PC_JR_EN
            JumpReg = ($urandom_range(0, 7) == 0);
            rs_data = {$urandom} & 32'hFFFF_FFFC;
`endif
            drive($urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            exp_next = model(exp_pc, instr, Branch, Zero, Jump, JumpReg, rs_data);
            check("rand_nextPC", nextPC, exp_next);
            tick();
            if (reset)   exp_pc = 32'h0;
            else if (en) exp_pc = exp_next;
            check("rand_PC", PC, exp_pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pc.md
# pc

Program-counter block for the single-cycle MIPS datapath. It holds the current instruction address in a register. Each cycle it computes the next address from the fetched instruction and the Branch, Jump and Zero control signals: sequential, conditional branch, or absolute jump. It sits between instruction memory (which it addresses) and the control unit/ALU (which supply Branch, Jump, Zero).

## Interface
- RESET_VECTOR, 32'h0000_0000, address loaded into PC on reset.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  PC write enable; 0 holds PC (stall).
- instr  input  32  current instruction (fields used: [25:0] jump index, [15:0] branch immediate).
- Zero  input  1  ALU zero flag for the current instruction.
- Branch  input  1  current instruction is a conditional branch (beq).
- Jump  input  1  current instruction is j/jal.
- PC  output  32  current instruction address (registered).
- nextPC  output  32  address PC will load at the next enabled edge (combinational).

## Operation
- pc4 = PC + 32'd4, modulo 2^32 (carry discarded).
- Branch target = pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
- Jump target = {pc4[31:28], instr[25:0], 2'b00}.
- Selection priority, highest first:
  - Jump=1 -> jump target. Branch and Zero are ignored.
  - Branch=1 and Zero=1 -> branch target.
  - Otherwise -> pc4. This includes Branch=1 with Zero=0.
- nextPC is a pure function of PC, instr, Zero, Branch and Jump. It has no dependence on en or reset.
- There is no alignment check. PC[1:0] propagates through the additions unchanged.

## Timing
- PC register, on rising clk:
  - reset=1 -> PC <= RESET_VECTOR. Reset takes precedence over en.
  - reset=0 and en=1 -> PC <= nextPC.
  - reset=0 and en=0 -> PC unchanged.
- Reset value of outputs: PC = RESET_VECTOR. nextPC = f(RESET_VECTOR, inputs), valid in the same cycle.
- Latency: nextPC settles combinationally within the cycle. PC reflects it one edge later.
- Reset asserted mid-operation discards any pending branch or jump. Reset deasserted on edge N -> first instruction fetch at RESET_VECTOR during cycle N, first update on edge N+1.
- Simultaneous Jump and Branch&Zero resolve by the priority above.

## Configuration
- PC_JR_EN defined:
  - Adds input JumpReg (1) and input rs_data (32).
  - JumpReg=1 selects nextPC = rs_data at highest priority, above Jump.
- PC_JR_EN undefined: these ports do not exist, and behaviour is exactly as above.

## Structure
- Shared package pc_pkg holds:
  - PC_WIDTH = 32 and PC_INC = 4.
  - Instruction field bounds: JIDX_MSB = 25, IMM_MSB = 15.
  - An enum for the next-PC source: SEQ, BRANCH, JUMP, and JR under PC_JR_EN.
- One combinational sub-module, pc_target_calc, computes pc4, the branch target, the jump target and the selected nextPC.
- Top-level pc contains only the register, the enable and the reset.

## Test plan
- PC=0, instr=32'h5555_5555, Branch=1, Zero=0, Jump=0 -> nextPC=32'h0000_0004.
- Same PC and instr, Branch=1, Zero=1, Jump=0 -> nextPC=32'h0001_5558. Then Jump=1 (any Branch/Zero) -> nextPC=32'h0555_5554.
- PC=32'h0000_0100, instr[15:0]=16'hFFFF, Branch=1, Zero=1 -> nextPC=32'h0000_0100 (self-loop, negative offset). PC=32'h0000_00FC with the same instr and Branch=1, Zero=0 -> nextPC=32'h0000_0100.
- PC=32'hFFFF_FFFC, no branch or jump -> nextPC=32'h0000_0000 (wrap). PC=32'hA000_0000, Jump=1, instr[25:0]=0 -> nextPC=32'hA000_0000.
- Clocked sequence: reset high for 2 edges -> PC=RESET_VECTOR. en=1 for 3 edges -> PC=4, 8, 12. en=0 -> PC holds 12. reset together with en=1 -> PC=RESET_VECTOR.
- With PC_JR_EN: JumpReg=1, Jump=1, rs_data=32'h0040_0020 -> nextPC=32'h0040_0020.
